// File: rtl/qspi_fill_arbiter.sv
// ============================================================================
// Module   : qspi_fill_arbiter
// Purpose  : Round-robin arbiter sharing one QSPI XIP line-fill engine between
//            two requesters, with merge of identical requests and fill watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qspi_fill_arbiter #(
  parameter int LAW     = 21,
  parameter int TIMEOUT = 64
) (
  input  logic           HCLK,
  input  logic           HRESET,
  input  logic           eng_ready,
  input  logic           r0_req,
  input  logic [LAW-1:0] r0_laddr,
  output logic           r0_ack,
  output logic           r0_err,
  input  logic           r1_req,
  input  logic [LAW-1:0] r1_laddr,
  output logic           r1_ack,
  output logic           r1_err,
  output logic [63:0]    line_data,
  output logic           grant_id,
  output logic           busy,
  output logic           fill_start,
  output logic [LAW-1:0] fill_laddr,
  input  logic           fill_done,
  input  logic [63:0]    fill_data,
  output logic           fill_abort
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic            r_last;
  logic            r_merge;
  logic            r_err_f;
  logic            r_grant;
  logic [LAW-1:0]  r_fill_laddr;
  logic [63:0]     r_line;
  logic            r_fill_start;
  logic            r_fill_abort;
  logic            r_r0_ack;
  logic            r_r0_err;
  logic            r_r1_ack;
  logic            r_r1_err;

  logic            w_any_req;
  logic            w_winner;
  logic            w_merge;
  logic            w_timeout;

  // On a tie the port that did not own the previous fill wins.
  assign w_any_req = r0_req | r1_req;
  assign w_winner  = (r0_req & r1_req) ? ~r_last : r1_req;
  assign w_merge   = r0_req & r1_req & (r0_laddr == r1_laddr);
  assign w_timeout = (r_timer == TW'(TIMEOUT - 1));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_last       <= 1'b1;
      r_merge      <= 1'b0;
      r_err_f      <= 1'b0;
      r_grant      <= 1'b0;
      r_fill_laddr <= '0;
      r_line       <= '0;
      r_fill_start <= 1'b0;
      r_fill_abort <= 1'b0;
      r_r0_ack     <= 1'b0;
      r_r0_err     <= 1'b0;
      r_r1_ack     <= 1'b0;
      r_r1_err     <= 1'b0;
    end else begin
      r_fill_start <= 1'b0;
      r_fill_abort <= 1'b0;
      r_r0_ack     <= 1'b0;
      r_r0_err     <= 1'b0;
      r_r1_ack     <= 1'b0;
      r_r1_err     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (eng_ready && w_any_req) begin
            r_grant      <= w_winner;
            r_fill_laddr <= w_winner ? r1_laddr : r0_laddr;
            r_merge      <= w_merge;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_fill_start <= 1'b1;
          r_timer      <= '0;
          r_state      <= ST_WAIT;
        end
        ST_WAIT: begin
          r_timer <= r_timer + TW'(1);
          // A completion on the watchdog's last cycle still counts as success.
          if (fill_done) begin
            r_line  <= fill_data;
            r_err_f <= 1'b0;
            r_state <= ST_RESP;
          end else if (w_timeout) begin
            r_fill_abort <= 1'b1;
            r_err_f      <= 1'b1;
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (r_err_f) begin
            r_r0_err <= ~r_grant | r_merge;
            r_r1_err <=  r_grant | r_merge;
          end else begin
            r_r0_ack <= ~r_grant | r_merge;
            r_r1_ack <=  r_grant | r_merge;
          end
          r_last  <= r_grant;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign r0_ack     = r_r0_ack;
  assign r0_err     = r_r0_err;
  assign r1_ack     = r_r1_ack;
  assign r1_err     = r_r1_err;
  assign line_data  = r_line;
  assign grant_id   = r_grant;
  assign busy       = (r_state != ST_IDLE);
  assign fill_start = r_fill_start;
  assign fill_laddr = r_fill_laddr;
  assign fill_abort = r_fill_abort;

endmodule

`default_nettype wire
